// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bundle for the pipelined ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_BCD = 4'd6,
        OP_ADC = 4'd7
    } op_e;

    localparam int OP_COUNT = 8;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic neg;
    } flags_t;

endpackage

// File: rtl/alu_bcd_add.sv
// Packed-BCD adder: ripple nibble chain from the LSB, carry-in 0, purely combinational.
// Non-BCD digits go through the same +6 correction; no error indication.
module alu_bcd_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int NIB = WIDTH / 4;

    always_comb begin
        logic [4:0] s;
        logic       cy;
        sum = '0;
        s   = '0;
        cy  = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            s  = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, cy};
            cy = (s > 5'd9);
            if (cy) begin
                s = s + 5'd6;
            end
            sum[4*i +: 4] = s[3:0];
        end
        carry = cy;
    end

endmodule

// File: rtl/alu_pipe_flags.sv
// Two-stage ALU: S1 captures operands plus the shared add/sub/adc sum, S2 registers result and flags.
// Accumulator (ACC, C_acc) reloads on every output handshake; acc/carry consumers wait for an empty pipe.
module alu_pipe_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       opcode,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             neg_flag,
    output logic             illegal_op
);
    logic             rdy_en_q, rdy_en_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH:0]   s1_sum_q, s1_sum_d;
    logic             s1_ovf_q, s1_ovf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    flags_t           s2_flg_q, s2_flg_d;
    logic             s2_ill_q, s2_ill_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cacc_q, cacc_d;

    logic             s2_adv, s1_adv, hazard, in_fire, out_fire;
    logic [WIDTH-1:0] op_a, b_eff, bcd_sum, res_c;
    logic             cin, bcd_cy, cy_c, ov_c, ill_c;
    logic [WIDTH:0]   add_full;

    alu_bcd_add #(.WIDTH(WIDTH)) u_bcd (
        .a     (s1_a_q),
        .b     (s1_b_q),
        .sum   (bcd_sum),
        .carry (bcd_cy)
    );

    // ACC and C_acc are only final once nothing is in flight, so their users wait for an empty pipe.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        hazard   = (use_acc || (opcode == OP_ADC)) && (s1_valid_q || s2_valid_q);
        in_ready = rdy_en_q && s1_adv && !hazard;
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;
        rdy_en_d = 1'b1;
    end

    // Shared adder: SUB is A + ~B + 1, so the stored top bit is inverted into a borrow.
    always_comb begin
        op_a     = use_acc ? acc_q : input_a;
        b_eff    = (opcode == OP_SUB) ? ~input_b : input_b;
        cin      = (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADC) ? cacc_q : 1'b0);
        add_full = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

        s1_valid_d = s1_adv ? in_fire : s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sum_d   = s1_sum_q;
        s1_ovf_d   = s1_ovf_q;
        if (in_fire) begin
            s1_a_d   = op_a;
            s1_b_d   = input_b;
            s1_op_d  = opcode;
            s1_sum_d = {add_full[WIDTH] ^ (opcode == OP_SUB), add_full[WIDTH-1:0]};
            s1_ovf_d = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_comb begin
        res_c = '0;
        cy_c  = 1'b0;
        ov_c  = 1'b0;
        ill_c = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_SUB, OP_ADC: begin
                res_c = s1_sum_q[WIDTH-1:0];
                cy_c  = s1_sum_q[WIDTH];
                ov_c  = s1_ovf_q;
            end
            OP_AND:  res_c = s1_a_q & s1_b_q;
            OP_OR:   res_c = s1_a_q | s1_b_q;
            OP_XOR:  res_c = s1_a_q ^ s1_b_q;
            OP_NOT:  res_c = ~s1_a_q;
            OP_BCD: begin
                res_c = bcd_sum;
                cy_c  = bcd_cy;
            end
            default: ill_c = 1'b1;
        endcase

        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flg_d   = s2_flg_q;
        s2_ill_d   = s2_ill_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d       = res_c;
                s2_flg_d.zero  = (res_c == '0);
                s2_flg_d.carry = cy_c;
                s2_flg_d.ovf   = ov_c;
                s2_flg_d.neg   = res_c[WIDTH-1];
                s2_ill_d       = ill_c;
            end
        end

        acc_d  = acc_q;
        cacc_d = cacc_q;
        if (out_fire) begin
            acc_d  = s2_res_q;
            cacc_d = s2_flg_q.carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_sum_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flg_q   <= '0;
            s2_ill_q   <= 1'b0;
            acc_q      <= '0;
            cacc_q     <= 1'b0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_sum_q   <= s1_sum_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flg_q   <= s2_flg_d;
            s2_ill_q   <= s2_ill_d;
            acc_q      <= acc_d;
            cacc_q     <= cacc_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign result     = s2_res_q;
    assign zero_flag  = s2_flg_q.zero;
    assign carry_flag = s2_flg_q.carry;
    assign ovf_flag   = s2_flg_q.ovf;
    assign neg_flag   = s2_flg_q.neg;
    assign illegal_op = s2_ill_q;

endmodule
